// File: rtl/mha_head_scheduler.sv
// mha_head_scheduler: round-robin time-multiplexing of one shared matmul core across attention-head buffer controllers
module mha_head_scheduler #(
  parameter int NUM_HEADS = 4,
  parameter int TILES_PER_GRANT = 2,
  parameter int MAX_FLAG = 16,
  localparam int HW = NUM_HEADS > 1 ? $clog2(NUM_HEADS) : 1,
  localparam int CW = $clog2(MAX_FLAG + 1),
  localparam int GW = $clog2(TILES_PER_GRANT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_HEADS-1:0] req,
  input  logic                 acc_done,
  output logic [NUM_HEADS-1:0] grant,
  output logic [HW-1:0]        grant_idx,
  output logic                 core_enable,
  output logic                 core_rst_n,
  output logic [NUM_HEADS-1:0] head_out_valid,
  output logic [NUM_HEADS-1:0] head_done,
  output logic                 all_done,
  output logic                 busy
);
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_SWITCH, S_RUN, S_DONE} state_e;
  state_e               state_q;
  logic [HW-1:0]        grant_idx_q;
  logic [HW-1:0]        rr_ptr_q;
  logic [GW-1:0]        grant_cnt_q;
  logic [CW-1:0]        head_cnt_q [NUM_HEADS];
  logic [NUM_HEADS-1:0] head_done_q;
  logic [NUM_HEADS-1:0] head_out_valid_q;
  logic                 acc_done_dly_q;
  logic [NUM_HEADS-1:0] eligible;
  logic [HW-1:0]        scan_idx;
  logic [HW-1:0]        arb_idx;
  logic                 arb_hit;
  logic                 acc_rise;
  logic                 tile_last;
  logic                 grant_last;
  logic [HW-1:0]        next_ptr;
  // first eligible head at or after rr_ptr; scanning backwards leaves the nearest hit last
  always_comb begin
    eligible = req & ~head_done_q;
    arb_hit = 1'b0;
    arb_idx = '0;
    scan_idx = '0;
    for (int i = NUM_HEADS - 1; i >= 0; i--) begin
      scan_idx = HW'((int'(rr_ptr_q) + i) % NUM_HEADS);
      if (eligible[scan_idx]) begin
        arb_hit = 1'b1;
        arb_idx = scan_idx;
      end
    end
  end
  assign acc_rise   = acc_done & ~acc_done_dly_q;
  assign tile_last  = head_cnt_q[grant_idx_q] >= CW'(MAX_FLAG - 1);
  assign grant_last = grant_cnt_q >= GW'(TILES_PER_GRANT - 1);
  assign next_ptr   = grant_idx_q == HW'(NUM_HEADS - 1) ? '0 : grant_idx_q + 1'b1;
  // scheduler FSM: arbitrate, flush the core for one cycle, run until the quota or the head's pass completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      grant_idx_q      <= '0;
      rr_ptr_q         <= '0;
      grant_cnt_q      <= '0;
      head_cnt_q       <= '{default: '0};
      head_done_q      <= '0;
      head_out_valid_q <= '0;
      acc_done_dly_q   <= 1'b0;
    end else begin
      acc_done_dly_q   <= acc_done;
      head_out_valid_q <= '0;
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_q     <= S_ARB;
          rr_ptr_q    <= '0;
          grant_cnt_q <= '0;
          head_cnt_q  <= '{default: '0};
          head_done_q <= '0;
        end
        S_ARB: if (&head_done_q) state_q <= S_DONE;
          else if (arb_hit) begin
            grant_idx_q <= arb_idx;
            state_q     <= S_SWITCH;
          end
        S_SWITCH: state_q <= S_RUN;
        S_RUN: if (acc_rise) begin
          head_out_valid_q[grant_idx_q] <= 1'b1;
          head_cnt_q[grant_idx_q] <= tile_last ? CW'(MAX_FLAG) : head_cnt_q[grant_idx_q] + 1'b1;
          grant_cnt_q <= grant_cnt_q + 1'b1;
          if (tile_last) head_done_q[grant_idx_q] <= 1'b1;
          if (tile_last || grant_last) begin
            rr_ptr_q    <= next_ptr;
            grant_cnt_q <= '0;
            state_q     <= S_ARB;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign grant          = (state_q == S_SWITCH || state_q == S_RUN) ? NUM_HEADS'(1) << grant_idx_q : '0;
  assign grant_idx      = grant_idx_q;
  assign core_enable    = state_q == S_RUN;
  assign core_rst_n     = state_q == S_RUN;
  assign head_out_valid = head_out_valid_q;
  assign head_done      = head_done_q;
  assign all_done       = state_q == S_DONE;
  assign busy           = !(state_q == S_IDLE || state_q == S_DONE);
endmodule
